stream_dest_router: RTL

//  Slave-side counterpart of the per-master round-robin arbiter in the streaming crossbar.

---
 rtl/stream_dest_router_pkg.sv | 15 +
 rtl/stream_dest_router_if.sv | 33 +++
 rtl/stream_dest_router_hold_reg.sv | 50 +++++
 rtl/stream_dest_router.sv | 124 ++++++++++++
 4 files changed

// File: rtl/stream_dest_router_pkg.sv
// Shared definitions for the stream crossbar slave-side router: FSM state encoding
// and default widths common to the crossbar blocks.
package stream_dest_router_pkg;

    localparam int DEF_T_DATA_WIDTH = 8;
    localparam int DEF_M_DATA_COUNT = 3;
    localparam int DEF_T_DEST_WIDTH = $clog2(DEF_M_DATA_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no packet open
        ST_BUSY = 2'd1,  // route latched, packet in flight
        ST_DROP = 2'd2   // discarding a packet with an out-of-range destination
    } router_state_e;

endpackage

// File: rtl/stream_dest_router_if.sv
// Bundle of the router's stream input, arbiter handshake and master-side data signals.
// The slave modport is the router's view; master is the view of whatever drives it.
interface stream_dest_router_if
    import stream_dest_router_pkg::*;
#(
    parameter int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
    parameter int M_DATA_COUNT = DEF_M_DATA_COUNT,
    parameter int T_DEST_WIDTH = DEF_T_DEST_WIDTH
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic [T_DEST_WIDTH-1:0] s_dest_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [M_DATA_COUNT-1:0] req_o;
    logic [M_DATA_COUNT-1:0] last_o;
    logic [M_DATA_COUNT-1:0] grant_i;
    logic [M_DATA_COUNT-1:0] m_ready_i;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    drop_o;

    modport slave (
        input  s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i, m_ready_i,
        output s_ready_o, req_o, last_o, m_data_o, m_last_o, m_valid_o, drop_o
    );

    modport master (
        output s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i, m_ready_i,
        input  s_ready_o, req_o, last_o, m_data_o, m_last_o, m_valid_o, drop_o
    );
endinterface

// File: rtl/stream_dest_router_hold_reg.sv
// One-entry {data,last} holding register with load/unload; load wins over unload so an
// accept and a fire in the same cycle refill the entry without a bubble.
module stream_hold_reg #(
    parameter int T_DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    unload_i,
    input  logic [T_DATA_WIDTH-1:0] data_i,
    input  logic                    last_i,
    output logic                    valid_o,
    output logic [T_DATA_WIDTH-1:0] data_o,
    output logic                    last_o
);
    logic                    valid_q, valid_d;
    logic [T_DATA_WIDTH-1:0] data_q,  data_d;
    logic                    last_q,  last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data bits are reset too, so m_data_o reads zero during and after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
endmodule

// File: rtl/stream_dest_router.sv
// Slave-port router: latches the destination from a packet's first beat, requests that
// master's arbiter, and presents the held beat until the arbiter grants and the master takes it.
module stream_dest_router
    import stream_dest_router_pkg::*;
#(
    parameter int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
    parameter int M_DATA_COUNT = DEF_M_DATA_COUNT,
    parameter int T_DEST_WIDTH = DEF_T_DEST_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    stream_dest_router_if.slave bus
);
    localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = M_DATA_COUNT[T_DEST_WIDTH:0];

    router_state_e           state_q, state_d;
    logic [T_DEST_WIDTH-1:0] dest_q, dest_d;
    logic                    closed_q, closed_d;
    logic                    drop_q, drop_d;

    logic                    hold_valid, hold_last;
    logic [T_DATA_WIDTH-1:0] hold_data;
    logic [M_DATA_COUNT-1:0] dest_oh;
    logic                    grant_sel, ready_sel, fire;
    logic                    s_ready, accept, dest_ok, load;

    always_comb begin
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            dest_oh[i] = (dest_q == T_DEST_WIDTH'(i));
        end
    end

    // Reduction through the one-hot keeps the select safe for any dest_q encoding.
    assign grant_sel = |(bus.grant_i & dest_oh);
    assign ready_sel = |(bus.m_ready_i & dest_oh);
    assign fire      = hold_valid & grant_sel & ready_sel;
    assign dest_ok   = {1'b0, bus.s_dest_i} < DEST_LIMIT;

    always_comb begin
        s_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: s_ready = 1'b1;
            ST_BUSY: s_ready = (!hold_valid || fire) && !(hold_valid && hold_last) && !closed_q;
            ST_DROP: s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign accept = bus.s_valid_i & bus.s_ready_o;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        closed_d = closed_q;
        drop_d   = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dest_ok) begin
                        dest_d   = bus.s_dest_i;
                        load     = 1'b1;
                        closed_d = bus.s_last_i;
                        state_d  = ST_BUSY;
                    end else begin
                        drop_d = 1'b1;
                        if (!bus.s_last_i) state_d = ST_DROP;
                    end
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    load     = 1'b1;
                    closed_d = bus.s_last_i;
                end else if (fire && hold_last) begin
                    closed_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && bus.s_last_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dest_q   <= '0;
            closed_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            closed_q <= closed_d;
            drop_q   <= drop_d;
        end
    end

    stream_hold_reg #(
        .T_DATA_WIDTH(T_DATA_WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .unload_i(fire),
        .data_i  (bus.s_data_i),
        .last_i  (bus.s_last_i),
        .valid_o (hold_valid),
        .data_o  (hold_data),
        .last_o  (hold_last)
    );

    // Ready is forced low while reset is held; everything else is already zero from the registers.
    assign bus.s_ready_o = s_ready & ~rst;
    assign bus.req_o     = (state_q == ST_BUSY) ? dest_oh : '0;
    assign bus.last_o    = (state_q == ST_BUSY && hold_valid && hold_last) ? dest_oh : '0;
    assign bus.m_valid_o = hold_valid & grant_sel;
    assign bus.m_data_o  = hold_data;
    assign bus.m_last_o  = hold_last;
    assign bus.drop_o    = drop_q;
endmodule
